lbp_img_host: RTL and testbench
===============================

LBP_IMG_HOST -- requirements
Module: lbp_img_host

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: load_valid  in  1  image byte valid; load_data  in  8  gray pixel, raster order; load_ready  out  1  host accepts byte.
REQ-003 SHALL have ports: gray_ready  out  1  image available to engine; gray_req  in  1  engine read enable; gray_addr  in  14  {row[6:0],col[6:0]}; gray_data  out  8  pixel at gray_addr.
REQ-004 SHALL have ports: lbp_valid  in  1  result write strobe; lbp_addr  in  14  {row,col}; lbp_data  in  8  LBP code; finish  in  1  engine done.
REQ-005 SHALL have ports: res_valid  out  1  result byte valid; res_ready  in  1  sink accepts; res_addr  out  14  raster index of res_data; res_data  out  8  LBP result; done  out  1  all results drained; err  out  1  sticky protocol error.
REQ-006 SHALL have parameter: IMG_W, default 128, image width and height (power of two; 14-bit address = 2*log2(IMG_W)).

Function
REQ-007 SHALL hold two 16384x8 arrays: gray_mem (source image) and lbp_mem (results); arrays are not reset.
REQ-008 SHALL implement FSM LOAD -> SERVE -> DRAIN -> DONE; DONE is terminal until reset.
REQ-009 LOAD: load_ready=1; byte accepted when load_valid&&load_ready, written to gray_mem[load_cnt], load_cnt+1.
REQ-010 LOAD: on acceptance with load_cnt==16383, SHALL enter SERVE next cycle; load_cnt wraps to 0.
REQ-011 SERVE: gray_ready=1 registered (high from first SERVE cycle, low in all other states).
REQ-012 SERVE: gray_data SHALL equal gray_mem[gray_addr] combinationally, same cycle as gray_addr (zero latency), when gray_req=1; gray_data=0 when gray_req=0 or state!=SERVE.
REQ-013 SERVE: on lbp_valid=1 with interior address (row,col in 1..126), lbp_mem[lbp_addr]<=lbp_data, wr_cnt+1 (14-bit, saturating at 16383).
REQ-014 SERVE: lbp_valid with border address (row or col 0 or 127) SHALL not write memory and SHALL set err.
REQ-015 SERVE: finish=1 SHALL enter DRAIN next cycle; a lbp_valid in the same cycle is captured first.
REQ-016 On SERVE->DRAIN, wr_cnt != 15876 (126*126) SHALL set err; duplicate writes are counted, not detected.
REQ-017 lbp_valid or gray_req outside SERVE SHALL be ignored, no err.
REQ-018 DRAIN: res_addr steps 0..16383; res_valid=1; res_data = 0 for border addresses, else lbp_mem[res_addr].
REQ-019 DRAIN: res_addr advances only on res_valid&&res_ready; res_addr/res_data SHALL stay stable while res_valid&&!res_ready.
REQ-020 DRAIN: transfer at res_addr==16383 SHALL enter DONE next cycle; res_valid=0 from then.
REQ-021 DONE: done=1, all handshake outputs 0.
REQ-022 err SHALL be sticky until reset and SHALL not alter FSM flow.

Reset
REQ-023 reset=1 SHALL immediately force: state=LOAD, load_cnt=0, wr_cnt=0, res_addr=0, gray_ready=0, res_valid=0, done=0, err=0.
REQ-024 load_ready SHALL be 0 while reset=1 and 1 in the first cycle after release.
REQ-025 Reset mid-LOAD/SERVE/DRAIN SHALL abort and restart at LOAD; array contents undefined, reload required.

Verification
REQ-026 Load 16384 bytes pixel=(addr*7)&0xFF with random load_valid gaps -> gray_ready rises exactly 1 cycle after last accept; load_ready low thereafter.
REQ-027 SERVE, gray_req=1, gray_addr=0x0081 -> gray_data=0x87 in same cycle; gray_req=0 -> gray_data=0.
REQ-028 Full LBP engine run on loaded image -> 15876 writes, finish, DRAIN output matches golden LBP map, borders 0, err=0, done=1.
REQ-029 Write lbp_valid at lbp_addr=0x0000 data 0xFF -> err=1, drained byte at addr 0 = 0x00.
REQ-030 DRAIN with res_ready toggling 1/0 per cycle -> each address emitted once, stable while stalled, done after 16384 transfers.
REQ-031 Assert reset mid-DRAIN at res_addr=500 -> next cycle state LOAD, res_valid=0, done=0, load_ready=1 after release.

Source files
------------

// File: rtl/lbp_img_host_if.sv
// lbp_img_host_if: groups the loader, engine and result-sink signals of the
// LBP image host into one bundle.
//   load_*  : byte stream of the gray image in raster order (valid/ready)
//   gray_*  : zero-latency read port the LBP engine uses to fetch pixels
//   lbp_*   : result write strobe from the engine, plus finish
//   res_*   : raster-ordered drain of the LBP map (valid/ready)
//   done    : all results drained; err: sticky protocol error
// slave  = the host (lbp_img_host), master = whoever drives it.
interface lbp_img_host_if #(
  parameter int AW = 14
);
  logic          load_valid;
  logic [7:0]    load_data;
  logic          load_ready;

  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;

  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_addr;
  logic [7:0]    res_data;
  logic          done;
  logic          err;

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_ready,
    output load_ready, gray_ready, gray_data,
           res_valid, res_addr, res_data, done, err
  );

  modport master (
    output load_valid, load_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_ready,
    input  load_ready, gray_ready, gray_data,
           res_valid, res_addr, res_data, done, err
  );
endinterface

// File: rtl/lbp_img_host.sv
// lbp_img_host: image host for an LBP engine. Loads a square gray image,
// serves it to the engine through a zero-latency read port, collects the
// engine's LBP codes for interior pixels, then drains the full result map
// in raster order (border pixels forced to 0).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : lbp_img_host_if.slave (load / gray / lbp / res handshakes)
// Parameter IMG_W: image width = height, power of two.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accept image bytes into gray_mem, raster order
// ST_SERVE | engine reads gray_mem, writes interior codes into lbp_mem
// ST_DRAIN | stream lbp_mem out, one address per res handshake
// ST_DONE  | terminal; done=1 until reset
module lbp_img_host #(
  parameter int IMG_W = 128
) (
  input  logic          clk,
  input  logic          reset,
  lbp_img_host_if.slave bus
);
  localparam int LW   = $clog2(IMG_W);
  localparam int AW   = 2 * LW;
  localparam int NPIX = IMG_W * IMG_W;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [AW-1:0] WR_TARGET = AW'((IMG_W - 2) * (IMG_W - 2));
  localparam logic [LW-1:0] EDGE_HI   = LW'(IMG_W - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DRAIN, ST_DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] wr_cnt, wr_cnt_nx;
  logic [AW-1:0] res_addr;
  logic          gray_ready_q;
  logic          err_q;

  logic [7:0] gray_mem [NPIX];
  logic [7:0] lbp_mem  [NPIX];

  logic load_ready, load_acc;
  logic lbp_wr, lbp_bad, res_xfer, count_bad;

  function automatic logic is_border(input logic [AW-1:0] a);
    logic [LW-1:0] row, col;
    row = a[AW-1:LW];
    col = a[LW-1:0];
    return (row == '0) || (col == '0) || (row == EDGE_HI) || (col == EDGE_HI);
  endfunction

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_acc   = 1'b0;
    lbp_wr     = 1'b0;
    lbp_bad    = 1'b0;
    res_xfer   = 1'b0;
    wr_cnt_nx  = wr_cnt;
    count_bad  = 1'b0;

    case (state)
      ST_LOAD: begin
        // reset is folded in so load_ready reads 0 while reset is held
        load_ready = !reset;
        load_acc   = bus.load_valid && load_ready;
        if (load_acc && load_cnt == LAST_ADDR) state_nx = ST_SERVE;
      end
      ST_SERVE: begin
        lbp_wr  = bus.lbp_valid && !is_border(bus.lbp_addr);
        lbp_bad = bus.lbp_valid &&  is_border(bus.lbp_addr);
        if (lbp_wr && wr_cnt != '1) wr_cnt_nx = wr_cnt + 1'b1;
        // a write in the finish cycle counts toward the completeness check
        if (bus.finish) begin
          state_nx  = ST_DRAIN;
          count_bad = (wr_cnt_nx != WR_TARGET);
        end
      end
      ST_DRAIN: begin
        res_xfer = bus.res_ready;
        if (res_xfer && res_addr == LAST_ADDR) state_nx = ST_DONE;
      end
      default: state_nx = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt     <= '0;
      wr_cnt       <= '0;
      res_addr     <= '0;
      gray_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (load_acc) load_cnt <= load_cnt + 1'b1;
      wr_cnt <= wr_cnt_nx;
      // wraps to 0 after the last address, so res_addr reads 0 in ST_DONE
      if (res_xfer) res_addr <= res_addr + 1'b1;
      gray_ready_q <= (state_nx == ST_SERVE);
      if (lbp_bad || count_bad) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_acc) gray_mem[load_cnt] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (lbp_wr) lbp_mem[bus.lbp_addr] <= bus.lbp_data;
  end

  assign bus.load_ready = load_ready;
  assign bus.gray_ready = gray_ready_q;
  assign bus.gray_data  = (state == ST_SERVE && bus.gray_req) ? gray_mem[bus.gray_addr] : 8'h00;
  assign bus.res_valid  = (state == ST_DRAIN);
  assign bus.res_addr   = res_addr;
  assign bus.res_data   = (state == ST_DRAIN && !is_border(res_addr)) ? lbp_mem[res_addr] : 8'h00;
  assign bus.done       = (state == ST_DONE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_lbp_img_host.sv
module tb_lbp_img_host;
  localparam int N    = 128;
  localparam int NPIX = N * N;
  localparam int AW   = 14;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lbp_img_host_if #(.AW(AW)) bus ();

  lbp_img_host #(.IMG_W(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [21:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 7) & 255);
  endfunction

  function automatic logic [7:0] lbp_code(input int r, input int c);
    int dr[8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
    int dc[8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
    logic [7:0] ctr, code;
    ctr  = pix(r * N + c);
    code = '0;
    for (int k = 0; k < 8; k++)
      code[7-k] = (pix((r + dr[k]) * N + c + dc[k]) >= ctr);
    return code;
  endfunction

  task automatic idle_inputs();
    bus.load_valid = 1'b0; bus.load_data = '0;
    bus.gray_req   = 1'b0; bus.gray_addr = '0;
    bus.lbp_valid  = 1'b0; bus.lbp_addr  = '0; bus.lbp_data = '0;
    bus.finish     = 1'b0; bus.res_ready = 1'b0;
  endtask

  task automatic load_image(input bit gaps);
    int  i   = 0;
    int  cyc = 0;
    bit  acc;
    while (i < NPIX && cyc < 30000) begin
      @(negedge clk);
      bus.load_valid = gaps ? ($urandom_range(7) != 0) : 1'b1;
      bus.load_data  = pix(i);
      #1;
      acc = bus.load_valid && bus.load_ready;
      if (acc && i == NPIX - 1) check_val("gray_ready_before_last", bus.gray_ready, 0);
      @(posedge clk);
      if (acc) i++;
      cyc++;
    end
    check_val("load_count", i, NPIX);
    @(negedge clk);
    bus.load_valid = 1'b0;
    #1;
    check_val("gray_ready_after_last", bus.gray_ready, 1);
    check_val("load_ready_in_serve", bus.load_ready, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers, cyc, a, gaddr;
    bit stalled;
    logic [21:0] held, e;
    logic [7:0] code;

    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check_val("rst_load_ready", bus.load_ready, 0);
    check_val("rst_gray_ready", bus.gray_ready, 0);
    check_val("rst_res_valid",  bus.res_valid,  0);
    check_val("rst_done",       bus.done,       0);
    check_val("rst_err",        bus.err,        0);
    check_val("rst_res_addr",   bus.res_addr,   0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("load_ready_after_rst", bus.load_ready, 1);

    // ---- run A: gapped load, short serve with border write, reset mid-drain
    load_image(1'b1);
    @(negedge clk);
    bus.gray_req = 1'b1; bus.gray_addr = 14'h0081;
    #1 check_val("gray_0081", bus.gray_data, 8'h87);
    @(negedge clk);
    bus.gray_req = 1'b0;
    #1 check_val("gray_req_low", bus.gray_data, 8'h00);
    @(negedge clk);
    bus.lbp_valid = 1'b1; bus.lbp_addr = {7'd1, 7'd1}; bus.lbp_data = 8'h5A;
    #1 check_val("err_before_border", bus.err, 0);
    @(negedge clk);
    bus.lbp_addr = 14'h0000; bus.lbp_data = 8'hFF;
    #1 check_val("err_interior_write", bus.err, 0);
    @(negedge clk);
    bus.lbp_valid = 1'b0; bus.finish = 1'b1;
    #1 check_val("err_border", bus.err, 1);
    @(negedge clk);
    bus.finish = 1'b0; bus.gray_req = 1'b1; bus.gray_addr = 14'h0081;
    #1;
    check_val("drain_res_valid", bus.res_valid, 1);
    check_val("drain_gray_ready", bus.gray_ready, 0);
    check_val("drain_gray_data", bus.gray_data, 8'h00);
    bus.gray_req = 1'b0;

    xfers = 0; cyc = 0;
    while (xfers < 500 && cyc < 1000) begin
      @(negedge clk);
      bus.res_ready = 1'b1;
      #1;
      if (bus.res_valid) begin
        check_val("runA_res_addr", bus.res_addr, xfers);
        if (xfers == 0) check_val("border_addr0_data", bus.res_data, 8'h00);
        xfers++;
      end
      cyc++;
    end
    check_val("runA_xfers", xfers, 500);
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1 check_val("res_addr_500", bus.res_addr, 500);
    reset = 1'b1;
    #1;
    check_val("midrst_res_valid",  bus.res_valid,  0);
    check_val("midrst_done",       bus.done,       0);
    check_val("midrst_err",        bus.err,        0);
    check_val("midrst_gray_ready", bus.gray_ready, 0);
    check_val("midrst_load_ready", bus.load_ready, 0);
    check_val("midrst_res_addr",   bus.res_addr,   0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("midrst_load_ready_rel", bus.load_ready, 1);
    check_val("midrst_res_valid_rel",  bus.res_valid,  0);

    // ---- run B: full load, full engine run, throttled drain
    load_image(1'b0);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        a = r * N + c;
        if (r == 0 || c == 0 || r == N - 1 || c == N - 1) begin
          exp_q.push_back({14'(a), 8'h00});
        end else begin
          code = lbp_code(r, c);
          exp_q.push_back({14'(a), code});
          @(negedge clk);
          bus.lbp_valid = 1'b1; bus.lbp_addr = 14'(a); bus.lbp_data = code;
          gaddr = (a * 37) & (NPIX - 1);
          bus.gray_req  = (c == 64);
          bus.gray_addr = 14'(gaddr);
          if (c == 64) begin
            #1 check_val("gray_serve", bus.gray_data, pix(gaddr));
          end
        end
      end
    end
    @(negedge clk);
    bus.lbp_valid = 1'b0; bus.gray_req = 1'b0; bus.finish = 1'b1;
    #1 check_val("err_before_finish", bus.err, 0);
    @(negedge clk);
    bus.finish = 1'b0;
    #1;
    check_val("err_after_finish", bus.err, 0);
    check_val("runB_res_valid", bus.res_valid, 1);

    // writes and reads during DRAIN must be ignored
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'd16254; bus.lbp_data = 8'hAA;
    bus.gray_req  = 1'b1; bus.gray_addr = 14'h0081;
    xfers = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (xfers < NPIX && cyc < 40000) begin
      @(negedge clk);
      bus.res_ready = cyc[0];
      #1;
      if (stalled) check_val("res_stable", {bus.res_addr, bus.res_data}, held);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check_val("res_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("res_xfer", {bus.res_addr, bus.res_data}, e);
        end
        xfers++;
        stalled = 1'b0;
      end else if (bus.res_valid) begin
        held    = {bus.res_addr, bus.res_data};
        stalled = 1'b1;
      end
      if (cyc % 1024 == 0) check_val("gray_outside_serve", bus.gray_data, 8'h00);
      cyc++;
    end
    check_val("drain_count", xfers, NPIX);
    @(negedge clk);
    idle_inputs();
    #1;
    check_val("final_done",       bus.done,       1);
    check_val("final_res_valid",  bus.res_valid,  0);
    check_val("final_err",        bus.err,        0);
    check_val("final_load_ready", bus.load_ready, 0);
    check_val("final_gray_ready", bus.gray_ready, 0);
    check_val("queue_empty",      exp_q.size(),   0);
    repeat (3) @(negedge clk);
    #1 check_val("done_sticky", bus.done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
